// File: rtl/half_sub_pkg.sv
// Shared definitions for the half subtractor: default counter width and
// the packed {diff, borrow} result encoding.
package half_sub_pkg;

    localparam int COUNT_W_DEFAULT = 16;

    typedef struct packed {
        logic diff;
        logic borrow;
    } sub_result_t;

endpackage

// File: rtl/half_subtractor_core.sv
// Pure combinational half subtractor: computes a - b as {diff, borrow}.
module half_subtractor_core
    import half_sub_pkg::*;
(
    input  logic        a,
    input  logic        b,
    output sub_result_t result
);

    assign result.diff   = a ^ b;
    assign result.borrow = ~a & b;

endmodule

// File: rtl/half_subtractor.sv
// Half subtractor with registered copies of the result, selectable output
// timing and a saturating count of clock edges that saw a borrow.
module half_subtractor
    import half_sub_pkg::*;
#(
    parameter bit REGISTER_OUTPUTS = 1'b0,
    parameter int COUNT_W          = COUNT_W_DEFAULT
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               a,
    input  logic               b,
    output logic               diff,
    output logic               borrow,
    output logic               diff_q,
    output logic               borrow_q,
    output logic [COUNT_W-1:0] borrow_count
);

    sub_result_t comb;

    half_subtractor_core u_core (
        .a      (a),
        .b      (b),
        .result (comb)
    );

    // Counter holds at all-ones instead of wrapping back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q       <= 1'b0;
            borrow_q     <= 1'b0;
            borrow_count <= '0;
        end else begin
            diff_q   <= comb.diff;
            borrow_q <= comb.borrow;
            if (comb.borrow && (borrow_count != {COUNT_W{1'b1}})) begin
                borrow_count <= borrow_count + COUNT_W'(1);
            end
        end
    end

    generate
        if (REGISTER_OUTPUTS) begin : g_reg_out
            assign diff   = diff_q;
            assign borrow = borrow_q;
        end else begin : g_comb_out
            assign diff   = comb.diff;
            assign borrow = comb.borrow;
        end
    endgenerate

endmodule

// File: tb/tb_half_subtractor.sv
// Self-checking bench for half_subtractor: combinational, registered and
// narrow-counter instances driven from a truth table and a scoreboard.
module tb_half_subtractor;

    typedef struct packed {
        logic diff;
        logic borrow;
    } exp_t;

    typedef struct {
        logic a;
        logic b;
        logic diff;
        logic borrow;
    } vec_t;

    logic clk;
    logic clk_en;
    logic rst_n;
    logic a;
    logic b;

    logic        comb_diff, comb_borrow, comb_diff_q, comb_borrow_q;
    logic [15:0] comb_count;
    logic        reg_diff, reg_borrow, reg_diff_q, reg_borrow_q;
    logic [15:0] reg_count;
    logic        sat_diff, sat_borrow, sat_diff_q, sat_borrow_q;
    logic [1:0]  sat_count;

    int   num_checks;
    int   num_fails;
    vec_t vecs[4];
    exp_t comb_q[$];
    exp_t reg_q[$];

    half_subtractor #(.REGISTER_OUTPUTS(1'b0), .COUNT_W(16)) dut_comb (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b),
        .diff(comb_diff), .borrow(comb_borrow),
        .diff_q(comb_diff_q), .borrow_q(comb_borrow_q),
        .borrow_count(comb_count)
    );

    half_subtractor #(.REGISTER_OUTPUTS(1'b1), .COUNT_W(16)) dut_reg (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b),
        .diff(reg_diff), .borrow(reg_borrow),
        .diff_q(reg_diff_q), .borrow_q(reg_borrow_q),
        .borrow_count(reg_count)
    );

    half_subtractor #(.REGISTER_OUTPUTS(1'b0), .COUNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b),
        .diff(sat_diff), .borrow(sat_borrow),
        .diff_q(sat_diff_q), .borrow_q(sat_borrow_q),
        .borrow_count(sat_count)
    );

    // The clock only toggles once clk_en is set, so early phases see no edges.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic na, input logic nb);
        vec_t v;
        v = vecs[{na, nb}];
        a = na;
        b = nb;
        comb_q.push_back('{diff: v.diff, borrow: v.borrow});
        reg_q.push_back('{diff: v.diff, borrow: v.borrow});
    endtask

    task automatic checkComb();
        exp_t e;
        if (comb_q.size() == 0) begin
            checkOutput("comb_scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = comb_q.pop_front();
            checkOutput("comb_diff", comb_diff, e.diff);
            checkOutput("comb_borrow", comb_borrow, e.borrow);
        end
    endtask

    task automatic checkReg();
        exp_t e;
        if (reg_q.size() == 0) begin
            checkOutput("reg_scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = reg_q.pop_front();
            checkOutput("reg_diff", reg_diff, e.diff);
            checkOutput("reg_borrow", reg_borrow, e.borrow);
            checkOutput("reg_diff_q", reg_diff_q, e.diff);
            checkOutput("reg_borrow_q", reg_borrow_q, e.borrow);
        end
    endtask

    // Entered just after a falling edge; returns on the next falling edge.
    task automatic runCycle(input logic na, input logic nb);
        applyStimulus(na, nb);
        #1;
        checkComb();
        @(posedge clk);
        #1;
        checkReg();
        @(negedge clk);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        comb_q.delete();
        reg_q.delete();
    endtask

    initial begin
        int exp_count;
        logic ra, rb;

        num_checks = 0;
        num_fails  = 0;
        vecs[0] = '{a: 1'b0, b: 1'b0, diff: 1'b0, borrow: 1'b0};
        vecs[1] = '{a: 1'b0, b: 1'b1, diff: 1'b1, borrow: 1'b1};
        vecs[2] = '{a: 1'b1, b: 1'b0, diff: 1'b1, borrow: 1'b0};
        vecs[3] = '{a: 1'b1, b: 1'b1, diff: 1'b0, borrow: 1'b0};

        clk    = 1'b0;
        clk_en = 1'b0;
        rst_n  = 1'b0;
        a      = 1'b0;
        b      = 1'b0;
        #10;
        checkOutput("reset_diff_q", reg_diff_q, 1'b0);
        checkOutput("reset_borrow_q", reg_borrow_q, 1'b0);
        checkOutput("reset_count", reg_count, 16'd0);
        checkOutput("reset_reg_diff", reg_diff, 1'b0);

        $display("[TB] truth table with clock stopped and reset held");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b);
            #5;
            checkComb();
            #5;
        end
        reg_q.delete();

        rst_n  = 1'b1;
        #2;
        clk_en = 1'b1;
        @(negedge clk);

        // Registered mode shows the previous inputs (1,1) until the edge.
        $display("[TB] registered output latency");
        applyStimulus(1'b0, 1'b1);
        #1;
        checkComb();
        checkOutput("pre_edge_reg_diff", reg_diff, 1'b0);
        checkOutput("pre_edge_reg_borrow", reg_borrow, 1'b0);
        @(posedge clk);
        #1;
        checkReg();
        @(negedge clk);

        $display("[TB] borrow counting");
        pulseReset();
        for (int i = 0; i < 5; i++) runCycle(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) runCycle(1'b1, 1'b1);
        checkOutput("count_after_5", reg_count, 16'd5);
        checkOutput("comb_count_after_5", comb_count, 16'd5);
        checkOutput("sat_count_after_5", sat_count, 2'd3);

        runCycle(1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_count", reg_count, 16'd0);
        checkOutput("async_reset_diff_q", reg_diff_q, 1'b0);
        checkOutput("async_reset_borrow_q", reg_borrow_q, 1'b0);
        checkOutput("async_reset_comb_diff", comb_diff, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);
        comb_q.delete();
        reg_q.delete();
        runCycle(1'b0, 1'b1);
        runCycle(1'b0, 1'b1);
        checkOutput("count_resume", reg_count, 16'd2);

        $display("[TB] counter saturation");
        pulseReset();
        runCycle(1'b0, 1'b1);
        runCycle(1'b0, 1'b1);
        checkOutput("sat_count_2", sat_count, 2'd2);
        for (int i = 0; i < 4; i++) runCycle(1'b0, 1'b1);
        checkOutput("sat_count_6", sat_count, 2'd3);
        checkOutput("wide_count_6", reg_count, 16'd6);

        $display("[TB] random stimulus");
        pulseReset();
        exp_count = 0;
        for (int i = 0; i < 1000; i++) begin
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            if (vecs[{ra, rb}].borrow) exp_count++;
            runCycle(ra, rb);
        end
        checkOutput("random_count", reg_count, 32'(exp_count));
        checkOutput("random_sat_count", sat_count, (exp_count > 3) ? 32'd3 : 32'(exp_count));

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
